// File: rtl/press_classifier.sv
// Turns a debounced button level into one-cycle short / long / double press events.
// Each gesture yields exactly one registered pulse; busy_o is high while a gesture is open.
module press_classifier #(
    parameter int long_cycles_p = 16,
    parameter int gap_cycles_p  = 8
) (
    input  logic clk_i,
    input  logic reset_ni,
    input  logic button_i,
    output logic short_o,
    output logic long_o,
    output logic double_o,
    output logic busy_o
);

    localparam int max_cycles_lp = (long_cycles_p > gap_cycles_p) ? long_cycles_p : gap_cycles_p;
    localparam int cnt_w_lp      = $clog2(max_cycles_lp + 1);

    localparam logic [cnt_w_lp-1:0] cnt_zero_lp = {cnt_w_lp{1'b0}};
    localparam logic [cnt_w_lp-1:0] cnt_one_lp  = {{(cnt_w_lp-1){1'b0}}, 1'b1};
    localparam logic [cnt_w_lp-1:0] cnt_max_lp  = {cnt_w_lp{1'b1}};
    localparam logic [cnt_w_lp-1:0] long_last_lp = cnt_w_lp'(long_cycles_p - 1);
    localparam logic [cnt_w_lp-1:0] gap_last_lp  = cnt_w_lp'(gap_cycles_p - 1);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        PRESS1    = 3'd1,
        WAIT_GAP  = 3'd2,
        PRESS2    = 3'd3,
        LONG_HOLD = 3'd4
    } state_e;

    state_e               state_r;
    state_e               state_nxt_s;
    logic [cnt_w_lp-1:0]  cnt_r;
    logic [cnt_w_lp-1:0]  cnt_nxt_s;
    logic [cnt_w_lp-1:0]  cnt_inc_s;
    logic                 btn_q_r;
    logic                 rise_s;
    logic                 at_long_s;
    logic                 at_gap_s;
    logic                 short_r;
    logic                 long_r;
    logic                 double_r;
    logic                 short_nxt_s;
    logic                 long_nxt_s;
    logic                 double_nxt_s;

    // btn_q resets high so a button held across reset release is not seen as a rise
    assign rise_s    = button_i & ~btn_q_r;
    assign at_long_s = (cnt_r == long_last_lp);
    assign at_gap_s  = (cnt_r == gap_last_lp);
    assign cnt_inc_s = (cnt_r == cnt_max_lp) ? cnt_r : (cnt_r + cnt_one_lp);

    // State, counter, edge register and pulse registers
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_r  <= IDLE;
            cnt_r    <= cnt_zero_lp;
            btn_q_r  <= 1'b1;
            short_r  <= 1'b0;
            long_r   <= 1'b0;
            double_r <= 1'b0;
        end else begin
            state_r  <= state_nxt_s;
            cnt_r    <= cnt_nxt_s;
            btn_q_r  <= button_i;
            short_r  <= short_nxt_s;
            long_r   <= long_nxt_s;
            double_r <= double_nxt_s;
        end
    end

    // Next-state and counter update
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        case (state_r)
            IDLE: begin
                if (rise_s) begin
                    state_nxt_s = PRESS1;
                    cnt_nxt_s   = cnt_one_lp;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            PRESS1: begin
                if (!button_i) begin
                    state_nxt_s = WAIT_GAP;
                    cnt_nxt_s   = cnt_one_lp;
                end else if (at_long_s) begin
                    state_nxt_s = LONG_HOLD;
                    cnt_nxt_s   = cnt_zero_lp;
                end else begin
                    cnt_nxt_s   = cnt_inc_s;
                end
            end
            WAIT_GAP: begin
                // a press in the final gap cycle still wins over the short
                if (button_i) begin
                    state_nxt_s = PRESS2;
                    cnt_nxt_s   = cnt_one_lp;
                end else if (at_gap_s) begin
                    state_nxt_s = IDLE;
                    cnt_nxt_s   = cnt_zero_lp;
                end else begin
                    cnt_nxt_s   = cnt_inc_s;
                end
            end
            PRESS2: begin
                if (!button_i) begin
                    state_nxt_s = IDLE;
                    cnt_nxt_s   = cnt_zero_lp;
                end else if (at_long_s) begin
                    state_nxt_s = LONG_HOLD;
                    cnt_nxt_s   = cnt_zero_lp;
                end else begin
                    cnt_nxt_s   = cnt_inc_s;
                end
            end
            LONG_HOLD: begin
                if (!button_i) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = LONG_HOLD;
                end
            end
            default: begin
                state_nxt_s = IDLE;
                cnt_nxt_s   = cnt_zero_lp;
            end
        endcase
    end

    // Event decode; each pulse belongs to a distinct state so at most one fires
    always_comb begin
        short_nxt_s  = 1'b0;
        long_nxt_s   = 1'b0;
        double_nxt_s = 1'b0;
        case (state_r)
            PRESS1:   long_nxt_s   = button_i & at_long_s;
            WAIT_GAP: short_nxt_s  = ~button_i & at_gap_s;
            PRESS2:   double_nxt_s = ~button_i | at_long_s;
            default: begin
                short_nxt_s  = 1'b0;
                long_nxt_s   = 1'b0;
                double_nxt_s = 1'b0;
            end
        endcase
    end

    assign short_o  = short_r;
    assign long_o   = long_r;
    assign double_o = double_r;
    assign busy_o   = (state_r != IDLE);

endmodule

// File: tb/tb_press_classifier.sv
// Directed bench for press_classifier with long_cycles_p=16, gap_cycles_p=8.
// Each gesture is a button bit pattern with hand-derived per-cycle expected pulse and busy masks.
module tb_press_classifier;

    logic clk_i;
    logic reset_ni;
    logic button_i;
    logic short_o;
    logic long_o;
    logic double_o;
    logic busy_o;

    int n_checks;
    int n_fails;

    press_classifier #(
        .long_cycles_p(16),
        .gap_cycles_p (8)
    ) dut (
        .clk_i   (clk_i),
        .reset_ni(reset_ni),
        .button_i(button_i),
        .short_o (short_o),
        .long_o  (long_o),
        .double_o(double_o),
        .busy_o  (busy_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] bits(input int lo, input int hi);
        logic [63:0] r;
        r = 64'd0;
        for (int i = 0; i < 64; i++) begin
            if (i >= lo && i <= hi) r[i] = 1'b1;
        end
        return r;
    endfunction

    // Called #1 after a rising edge: outputs visible now belong to cycle 0 of the pattern.
    task automatic run_pat(input string name, input logic [63:0] pat, input int len,
                           input logic [63:0] sm, input logic [63:0] lm,
                           input logic [63:0] dm, input logic [63:0] bm);
        for (int c = 0; c < len; c++) begin
            button_i = pat[c];
            check_eq($sformatf("%s_short_c%0d", name, c),  short_o,  sm[c]);
            check_eq($sformatf("%s_long_c%0d", name, c),   long_o,   lm[c]);
            check_eq($sformatf("%s_double_c%0d", name, c), double_o, dm[c]);
            check_eq($sformatf("%s_busy_c%0d", name, c),   busy_o,   bm[c]);
            @(posedge clk_i);
            #1;
        end
    endtask

    task automatic check_all_low(input string name);
        check_eq({name, "_short"},  short_o,  1'b0);
        check_eq({name, "_long"},   long_o,   1'b0);
        check_eq({name, "_double"}, double_o, 1'b0);
        check_eq({name, "_busy"},   busy_o,   1'b0);
    endtask

    initial begin
        n_checks = 0;
        n_fails  = 0;
        button_i = 1'b1;
        reset_ni = 1'b0;
        #12;
        check_all_low("reset");
        @(negedge clk_i);
        reset_ni = 1'b1;
        @(posedge clk_i);
        #1;

        // 1: held through reset release is ignored; then release and a 3-cycle press is a short
        run_pat("t1_held", bits(0, 39), 40, 64'd0, 64'd0, 64'd0, 64'd0);
        run_pat("t1_after", bits(2, 4), 16, bits(13, 13), 64'd0, 64'd0, bits(3, 12));

        // 2: 5-cycle press, first low at 5 -> short in 13
        run_pat("t2_short", bits(0, 4), 16, bits(13, 13), 64'd0, 64'd0, bits(1, 12));

        // 3: held 20 cycles -> long in 16, silent release at 20, idle from 21
        run_pat("t3_long", bits(0, 19), 24, 64'd0, bits(16, 16), 64'd0, bits(1, 20));

        // 4: 3 high, 4 low, 3 high, release at 10 -> double in 11
        run_pat("t4_double", bits(0, 2) | bits(7, 9), 20, 64'd0, 64'd0, bits(11, 11), bits(1, 10));

        // 5a: 7-cycle gap, press in last gap cycle -> double
        run_pat("t5a_gap7", bits(0, 2) | bits(10, 11), 24, 64'd0, 64'd0, bits(13, 13), bits(1, 12));

        // 5b: 8-cycle gap -> short in 11, second press starts new gesture -> short in 21
        run_pat("t5b_gap8", bits(0, 2) | bits(11, 12), 26, bits(11, 11) | bits(21, 21),
                64'd0, 64'd0, bits(1, 10) | bits(12, 20));

        // 6: reset in cycle 6 of a held press
        run_pat("t6_pre", bits(0, 5), 6, 64'd0, 64'd0, 64'd0, bits(1, 5));
        check_eq("t6_busy_before_rst", busy_o, 1'b1);
        #2;
        reset_ni = 1'b0;
        #1;
        check_all_low("t6_async_rst");
        @(posedge clk_i);
        @(posedge clk_i);
        #1;
        check_all_low("t6_in_rst");
        @(negedge clk_i);
        reset_ni = 1'b1;
        @(posedge clk_i);
        #1;
        run_pat("t6_held", bits(0, 29), 30, 64'd0, 64'd0, 64'd0, 64'd0);
        run_pat("t6_repress", bits(2, 3), 16, bits(12, 12), 64'd0, 64'd0, bits(3, 11));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
